ring_wr_cntrl: RTL and testbench

- Write-side controller for the digitizer sample ring buffer; the counterpart of the readout address controller.
- Writes ADC samples continuously into the ring, guarantees a pre-trigger history, and counts a programmable number of post-trigger samples.
- Then freezes the write pointer and hands it to the readout side via rd_request/ain.
- Re-arms once the readout side reports completion on ro_done_n.

---
 rtl/ring_wr_cntrl_pkg.sv | 20 ++
 rtl/ring_wr_cntrl_ptr.sv | 44 ++++
 rtl/ring_wr_cntrl.sv | 168 ++++++++++++++++
 tb/tb_ring_wr_cntrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_wr_cntrl_pkg.sv
// Shared definitions for the sample-ring write controller: state encoding and
// helpers used by the controller and by status readback.
package ring_wr_cntrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 3'd0,
    FILL      = 3'd1,
    WAIT_TRIG = 3'd2,
    POST      = 3'd3,
    READOUT   = 3'd4
  } state_e;

  // States in which a sample is written into the ring every cycle.
  function automatic logic is_writing(state_e s);
    return (s == FILL) || (s == WAIT_TRIG) || (s == POST);
  endfunction

endpackage

// File: rtl/ring_wr_cntrl_ptr.sv
// Ring write pointer: advances after each completed write and captures the
// next-write address into ain when the controller freezes the capture.
module ring_wr_ptr #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  input  logic            capture,
  output logic [SIZE-1:0] wr_addr,
  output logic [SIZE-1:0] ain
);

  logic [SIZE-1:0] wr_addr_q;
  logic [SIZE-1:0] wr_addr_d;
  logic [SIZE-1:0] ain_q;
  logic [SIZE-1:0] ain_d;

  // ain takes the already-advanced pointer so it points one past the last write.
  always_comb begin
    wr_addr_d = wr_addr_q;
    if (inc) begin
      wr_addr_d = SIZE'(wr_addr_q + 1'b1);
    end
    ain_d = ain_q;
    if (capture) begin
      ain_d = wr_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_addr_q <= '0;
      ain_q     <= '0;
    end else begin
      wr_addr_q <= wr_addr_d;
      ain_q     <= ain_d;
    end
  end

  assign wr_addr = wr_addr_q;
  assign ain     = ain_q;

endmodule

// File: rtl/ring_wr_cntrl.sv
// Write-side controller for the digitizer sample ring: continuous capture with
// guaranteed pre-trigger history, post-trigger count, then hand-off to readout.
module ring_wr_cntrl
  import ring_wr_cntrl_pkg::*;
#(
  parameter int SIZE   = 8,
  parameter int DWIDTH = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              trig,
  input  logic [SIZE-1:0]   pretrig_i,
  input  logic [SIZE-1:0]   posttrig_i,
  input  logic [DWIDTH-1:0] adc_i,
  input  logic              ro_done_n,
  output logic              wr_en,
  output logic [SIZE-1:0]   wr_addr,
  output logic [DWIDTH-1:0] wr_data,
  output logic [SIZE-1:0]   ain,
  output logic              rd_request,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [SIZE-1:0]   fill_cnt_q, fill_cnt_d;
  logic [SIZE-1:0]   post_cnt_q, post_cnt_d;
  logic [SIZE-1:0]   pretrig_q, pretrig_d;
  logic [SIZE-1:0]   posttrig_q, posttrig_d;
  logic              ro_first_q, ro_first_d;
  logic              rd_request_q, rd_request_d;
  logic              wr_en_q, wr_en_d;
  logic              busy_q, busy_d;
  logic [DWIDTH-1:0] wr_data_q;
  logic [SIZE:0]     fill_next;
  logic              capture;

  assign fill_next = {1'b0, fill_cnt_q} + (SIZE + 1)'(1);

  always_comb begin
    state_d      = state_q;
    fill_cnt_d   = fill_cnt_q;
    post_cnt_d   = post_cnt_q;
    pretrig_d    = pretrig_q;
    posttrig_d   = posttrig_q;
    rd_request_d = rd_request_q;
    ro_first_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (arm) begin
          pretrig_d  = pretrig_i;
          posttrig_d = posttrig_i;
          fill_cnt_d = '0;
          state_d    = FILL;
        end
      end

      FILL: begin
        if (!arm) begin
          state_d = IDLE;
        end else begin
          fill_cnt_d = SIZE'(fill_next);
          if (fill_next >= {1'b0, pretrig_q}) begin
            state_d = WAIT_TRIG;
          end
        end
      end

      // Disarm takes priority over a coincident trigger.
      WAIT_TRIG: begin
        if (!arm) begin
          state_d = IDLE;
        end else if (trig) begin
          if (posttrig_q == '0) begin
            state_d = READOUT;
          end else begin
            post_cnt_d = posttrig_q;
            state_d    = POST;
          end
        end
      end

      POST: begin
        if (!arm) begin
          state_d = IDLE;
        end else begin
          post_cnt_d = SIZE'(post_cnt_q - 1'b1);
          if (post_cnt_q == SIZE'(1)) begin
            state_d = READOUT;
          end
        end
      end

      // The first cycle is skipped: ro_done_n is stale until the readout side
      // has loaded its counter from ain.
      READOUT: begin
        if (!ro_first_q && !ro_done_n) begin
          rd_request_d = 1'b0;
          if (arm) begin
            pretrig_d  = pretrig_i;
            posttrig_d = posttrig_i;
            fill_cnt_d = '0;
            state_d    = FILL;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if ((state_d == READOUT) && (state_q != READOUT)) begin
      rd_request_d = 1'b1;
      ro_first_d   = 1'b1;
    end
  end

  assign capture = (state_d == READOUT) && (state_q != READOUT);
  assign wr_en_d = is_writing(state_d);
  assign busy_d  = (state_d != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fill_cnt_q   <= '0;
      post_cnt_q   <= '0;
      pretrig_q    <= '0;
      posttrig_q   <= '0;
      ro_first_q   <= 1'b0;
      rd_request_q <= 1'b0;
      wr_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      fill_cnt_q   <= fill_cnt_d;
      post_cnt_q   <= post_cnt_d;
      pretrig_q    <= pretrig_d;
      posttrig_q   <= posttrig_d;
      ro_first_q   <= ro_first_d;
      rd_request_q <= rd_request_d;
      wr_en_q      <= wr_en_d;
      busy_q       <= busy_d;
      wr_data_q    <= adc_i;
    end
  end

  // A write is in flight whenever wr_en is high, so the pointer advances on
  // the edge that completes it.
  ring_wr_ptr #(
    .SIZE (SIZE)
  ) u_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (wr_en_q),
    .capture (capture),
    .wr_addr (wr_addr),
    .ain     (ain)
  );

  assign wr_en      = wr_en_q;
  assign wr_data    = wr_data_q;
  assign rd_request = rd_request_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_ring_wr_cntrl.sv
// Directed bench for ring_wr_cntrl: expected writes are queued as samples are
// driven and popped as the DUT presents them on the ring write port.
module tb_ring_wr_cntrl;

  logic        clk;
  logic        rst_n;
  logic        arm;
  logic        trig;
  logic [7:0]  pretrig_i;
  logic [7:0]  posttrig_i;
  logic [11:0] adc_i;
  logic        ro_done_n;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [11:0] wr_data;
  logic [7:0]  ain;
  logic        rd_request;
  logic        busy;

  int checks;
  int failures;

  typedef struct packed {
    logic [7:0]  addr;
    logic [11:0] data;
  } wr_t;

  wr_t exp_q[$];

  ring_wr_cntrl #(
    .SIZE   (8),
    .DWIDTH (12)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .arm        (arm),
    .trig       (trig),
    .pretrig_i  (pretrig_i),
    .posttrig_i (posttrig_i),
    .adc_i      (adc_i),
    .ro_done_n  (ro_done_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .ain        (ain),
    .rd_request (rd_request),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: new ADC sample, optional expected write, then check the port.
  task automatic cyc(input logic exp_wr, input logic [7:0] exp_addr);
    wr_t e;
    adc_i = 12'($urandom);
    if (exp_wr) exp_q.push_back({exp_addr, adc_i});
    @(posedge clk);
    #1;
    chk("wr_en", {31'b0, wr_en}, {31'b0, exp_wr});
    if (exp_wr) begin
      e = exp_q.pop_front();
      chk("wr_addr", {24'b0, wr_addr}, {24'b0, e.addr});
      chk("wr_data", {20'b0, wr_data}, {20'b0, e.data});
    end
  endtask

  task automatic run_wr(input int first, input int last);
    for (int a = first; a <= last; a++) cyc(1'b1, 8'(a));
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    arm        = 1'b0;
    trig       = 1'b0;
    pretrig_i  = '0;
    posttrig_i = '0;
    ro_done_n  = 1'b1;
    adc_i      = '0;

    // Reset state
    cyc(1'b0, 8'h00);
    cyc(1'b0, 8'h00);
    chk("rst_wr_addr", {24'b0, wr_addr}, 32'h0);
    chk("rst_wr_data", {20'b0, wr_data}, 32'h0);
    chk("rst_ain", {24'b0, ain}, 32'h0);
    chk("rst_rd_request", {31'b0, rd_request}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    rst_n = 1'b1;
    cyc(1'b0, 8'h00);
    chk("idle_busy", {31'b0, busy}, 32'h0);

    // Basic capture: pretrig=4, posttrig=3, trigger on the write at 10
    pretrig_i  = 8'd4;
    posttrig_i = 8'd3;
    arm        = 1'b1;
    run_wr(0, 10);
    chk("fill_busy", {31'b0, busy}, 32'h1);
    trig = 1'b1;
    cyc(1'b1, 8'd11);
    trig = 1'b0;
    run_wr(12, 13);
    cyc(1'b0, 8'h00);
    chk("basic_rd_request", {31'b0, rd_request}, 32'h1);
    chk("basic_ain", {24'b0, ain}, 32'd14);
    chk("basic_wr_addr", {24'b0, wr_addr}, 32'd14);
    chk("basic_busy", {31'b0, busy}, 32'h1);
    // ro_done_n low in the first READOUT cycle must be ignored
    ro_done_n = 1'b0;
    cyc(1'b0, 8'h00);
    chk("ro_first_ignored", {31'b0, rd_request}, 32'h1);
    ro_done_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 8'h00);
      chk("ro_hold_rd_request", {31'b0, rd_request}, 32'h1);
      chk("ro_hold_ain", {24'b0, ain}, 32'd14);
    end
    // Completion with arm high restarts FILL at 14 with new parameters
    pretrig_i  = 8'd8;
    posttrig_i = 8'd2;
    ro_done_n  = 1'b0;
    cyc(1'b1, 8'd14);
    ro_done_n = 1'b1;
    chk("rearm_rd_request", {31'b0, rd_request}, 32'h0);

    // Early trigger in FILL is ignored; trigger after 8 writes accepted
    cyc(1'b1, 8'd15);
    cyc(1'b1, 8'd16);
    trig = 1'b1;
    cyc(1'b1, 8'd17);
    trig = 1'b0;
    run_wr(18, 22);
    trig = 1'b1;
    cyc(1'b1, 8'd23);
    trig = 1'b0;
    cyc(1'b1, 8'd24);
    cyc(1'b0, 8'h00);
    chk("early_rd_request", {31'b0, rd_request}, 32'h1);
    chk("early_ain", {24'b0, ain}, 32'd25);
    cyc(1'b0, 8'h00);
    arm       = 1'b0;
    ro_done_n = 1'b0;
    cyc(1'b0, 8'h00);
    ro_done_n = 1'b1;
    chk("done_idle_rd_request", {31'b0, rd_request}, 32'h0);
    chk("done_idle_busy", {31'b0, busy}, 32'h0);
    chk("done_idle_wr_addr", {24'b0, wr_addr}, 32'd25);

    // Wrap: pretrig=0, trigger on the write at 0xFD, posttrig=4
    pretrig_i  = 8'd0;
    posttrig_i = 8'd4;
    arm        = 1'b1;
    run_wr(25, 8'hFD);
    trig = 1'b1;
    cyc(1'b1, 8'hFE);
    trig = 1'b0;
    cyc(1'b1, 8'hFF);
    cyc(1'b1, 8'h00);
    cyc(1'b1, 8'h01);
    cyc(1'b0, 8'h00);
    chk("wrap_rd_request", {31'b0, rd_request}, 32'h1);
    chk("wrap_ain", {24'b0, ain}, 32'h02);
    pretrig_i  = 8'd2;
    posttrig_i = 8'd0;
    cyc(1'b0, 8'h00);
    ro_done_n = 1'b0;
    cyc(1'b1, 8'h02);
    ro_done_n = 1'b1;

    // posttrig=0: only the trigger write, READOUT on the next edge
    run_wr(3, 5);
    trig = 1'b1;
    cyc(1'b0, 8'h00);
    trig = 1'b0;
    chk("pt0_rd_request", {31'b0, rd_request}, 32'h1);
    chk("pt0_ain", {24'b0, ain}, 32'd6);
    pretrig_i  = 8'd3;
    posttrig_i = 8'd2;
    cyc(1'b0, 8'h00);
    ro_done_n = 1'b0;
    cyc(1'b1, 8'd6);
    ro_done_n = 1'b1;

    // Disarm in POST with post_cnt=2: no readout, pointer then holds
    run_wr(7, 9);
    trig = 1'b1;
    cyc(1'b1, 8'd10);
    trig = 1'b0;
    arm  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 8'h00);
      chk("disarm_rd_request", {31'b0, rd_request}, 32'h0);
      chk("disarm_wr_addr", {24'b0, wr_addr}, 32'd11);
    end
    chk("disarm_busy", {31'b0, busy}, 32'h0);
    chk("disarm_ain", {24'b0, ain}, 32'd6);

    // Trigger and disarm together in WAIT_TRIG: disarm wins
    pretrig_i  = 8'd1;
    posttrig_i = 8'd1;
    arm        = 1'b1;
    run_wr(11, 12);
    trig = 1'b1;
    arm  = 1'b0;
    cyc(1'b0, 8'h00);
    trig = 1'b0;
    chk("trig_disarm_rd_request", {31'b0, rd_request}, 32'h0);
    chk("trig_disarm_busy", {31'b0, busy}, 32'h0);
    chk("trig_disarm_wr_addr", {24'b0, wr_addr}, 32'd13);

    // Reset mid-POST at wr_addr 0x37
    pretrig_i  = 8'd0;
    posttrig_i = 8'd8;
    arm        = 1'b1;
    run_wr(13, 8'h36);
    trig = 1'b1;
    cyc(1'b1, 8'h37);
    trig  = 1'b0;
    rst_n = 1'b0;
    cyc(1'b0, 8'h00);
    chk("rst_post_wr_addr", {24'b0, wr_addr}, 32'h0);
    chk("rst_post_rd_request", {31'b0, rd_request}, 32'h0);
    chk("rst_post_busy", {31'b0, busy}, 32'h0);
    chk("rst_post_wr_data", {20'b0, wr_data}, 32'h0);

    // Reset mid-readout drops rd_request
    rst_n      = 1'b1;
    posttrig_i = 8'd0;
    run_wr(0, 1);
    trig = 1'b1;
    cyc(1'b0, 8'h00);
    trig = 1'b0;
    chk("ro2_rd_request", {31'b0, rd_request}, 32'h1);
    chk("ro2_ain", {24'b0, ain}, 32'd2);
    rst_n = 1'b0;
    cyc(1'b0, 8'h00);
    chk("rst_ro_rd_request", {31'b0, rd_request}, 32'h0);
    chk("rst_ro_ain", {24'b0, ain}, 32'h0);
    chk("rst_ro_busy", {31'b0, busy}, 32'h0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
